// File: rtl/instr_register_mc.sv
// Multi-cycle instruction register: accepts one instruction per handshake, computes its
// result (single-cycle or iterative DIV/MOD/POW) and stores it in a DEPTH-entry register file.
module instr_register_mc #(
    parameter int OP_WIDTH  = 32,
    parameter int RES_WIDTH = 64,
    parameter int DEPTH     = 32,
    parameter int AUTO_INC  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [3:0]                 opcode,
    input  logic [OP_WIDTH-1:0]        operand_a,
    input  logic [OP_WIDTH-1:0]        operand_b,
    input  logic [$clog2(DEPTH)-1:0]   write_pointer,
    input  logic [$clog2(DEPTH)-1:0]   read_pointer,
    output logic [3:0]                 rd_opcode,
    output logic [OP_WIDTH-1:0]        rd_operand_a,
    output logic [OP_WIDTH-1:0]        rd_operand_b,
    output logic [RES_WIDTH-1:0]       rd_result,
    output logic                       rd_valid,
    output logic                       wr_done,
    output logic [$clog2(DEPTH)-1:0]   wr_done_ptr,
    output logic [$clog2(DEPTH)-1:0]   wr_count,
    output logic                       illegal_op
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(OP_WIDTH + 1);

    localparam logic [3:0] OP_ZERO  = 4'd0;
    localparam logic [3:0] OP_PASSA = 4'd1;
    localparam logic [3:0] OP_PASSB = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MULT  = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_MOD   = 4'd7;
    localparam logic [3:0] OP_POW   = 4'd8;

    localparam logic [RES_WIDTH-1:0] RES_ZERO = {RES_WIDTH{1'b0}};
    localparam logic [RES_WIDTH-1:0] RES_ONE  = {{(RES_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]           r_mem_op  [DEPTH];
    logic [OP_WIDTH-1:0]  r_mem_a   [DEPTH];
    logic [OP_WIDTH-1:0]  r_mem_b   [DEPTH];
    logic [RES_WIDTH-1:0] r_mem_res [DEPTH];
    logic [DEPTH-1:0]     r_mem_valid;

    logic [3:0]           r_cap_op;
    logic [OP_WIDTH-1:0]  r_cap_a;
    logic [OP_WIDTH-1:0]  r_cap_b;
    logic [AW-1:0]        r_cap_ptr;
    logic [CNT_W-1:0]     r_cnt;
    logic [OP_WIDTH-1:0]  r_quot;
    logic [OP_WIDTH-1:0]  r_rem;
    logic [OP_WIDTH-1:0]  r_div;
    logic [RES_WIDTH-1:0] r_pacc;
    logic [RES_WIDTH-1:0] r_pbase;
    logic [OP_WIDTH-1:0]  r_pexp;
    logic [AW-1:0]        r_wr_count;
    logic                 r_wr_done;
    logic [AW-1:0]        r_wr_done_ptr;
    logic                 r_illegal;

    logic                 w_accept;
    logic                 w_is_single;
    logic                 w_is_multi;
    logic                 w_is_illegal;
    logic                 w_last;
    logic [AW-1:0]        w_tgt_ptr;
    logic [RES_WIDTH-1:0] w_a_ext;
    logic [RES_WIDTH-1:0] w_b_ext;
    logic [OP_WIDTH-1:0]  w_a_mag;
    logic [OP_WIDTH-1:0]  w_b_mag;
    logic [OP_WIDTH:0]    w_rem_sh;
    logic [OP_WIDTH:0]    w_rem_sub;
    logic [RES_WIDTH-1:0] w_q_ext;
    logic [RES_WIDTH-1:0] w_r_ext;
    logic [RES_WIDTH-1:0] w_multi_res;
    logic                 w_wr_en;
    logic [AW-1:0]        w_wr_ptr;
    logic [3:0]           w_wr_op;
    logic [OP_WIDTH-1:0]  w_wr_a;
    logic [OP_WIDTH-1:0]  w_wr_b;
    logic [RES_WIDTH-1:0] w_wr_res;

    function automatic logic [RES_WIDTH-1:0] f_single(
        input logic [3:0]           op,
        input logic [RES_WIDTH-1:0] a,
        input logic [RES_WIDTH-1:0] b
    );
        case (op)
            OP_ZERO:  f_single = RES_ZERO;
            OP_PASSA: f_single = a;
            OP_PASSB: f_single = b;
            OP_ADD:   f_single = a + b;
            OP_SUB:   f_single = a - b;
            OP_MULT:  f_single = a * b;
            default:  f_single = RES_ZERO;
        endcase
    endfunction

    assign load_ready   = (r_state == S_IDLE);
    assign w_accept     = load_valid && (r_state == S_IDLE);
    assign w_is_single  = (opcode <= OP_MULT);
    assign w_is_multi   = (opcode >= OP_DIV) && (opcode <= OP_POW);
    assign w_is_illegal = (opcode > OP_POW);
    assign w_last       = (r_cnt == CNT_W'(OP_WIDTH));
    assign w_tgt_ptr    = (AUTO_INC != 0) ? r_wr_count : write_pointer;
    assign w_a_ext      = RES_WIDTH'($signed(operand_a));
    assign w_b_ext      = RES_WIDTH'($signed(operand_b));
    assign w_a_mag      = operand_a[OP_WIDTH-1] ? (-operand_a) : operand_a;
    assign w_b_mag      = operand_b[OP_WIDTH-1] ? (-operand_b) : operand_b;

    // Restoring division: shift in one dividend bit per cycle, MSB first
    assign w_rem_sh  = {r_rem, r_quot[OP_WIDTH-1]};
    assign w_rem_sub = w_rem_sh - {1'b0, r_div};
    assign w_q_ext   = RES_WIDTH'(r_quot);
    assign w_r_ext   = RES_WIDTH'(r_rem);

    // Sign fix-up and special cases for the iterative operations
    always_comb begin
        w_multi_res = RES_ZERO;
        case (r_cap_op)
            OP_DIV: begin
                if (r_cap_b == {OP_WIDTH{1'b0}}) begin
                    w_multi_res = RES_ZERO;
                end else if (r_cap_a[OP_WIDTH-1] ^ r_cap_b[OP_WIDTH-1]) begin
                    w_multi_res = -w_q_ext;
                end else begin
                    w_multi_res = w_q_ext;
                end
            end
            OP_MOD: begin
                if (r_cap_b == {OP_WIDTH{1'b0}}) begin
                    w_multi_res = RES_ZERO;
                end else if (r_cap_a[OP_WIDTH-1]) begin
                    w_multi_res = -w_r_ext;
                end else begin
                    w_multi_res = w_r_ext;
                end
            end
            OP_POW: begin
                if (r_cap_a == {OP_WIDTH{1'b0}}) begin
                    w_multi_res = RES_ZERO;
                end else if (r_cap_b == {OP_WIDTH{1'b0}}) begin
                    w_multi_res = RES_ONE;
                end else if (r_cap_b[OP_WIDTH-1]) begin
                    w_multi_res = RES_ZERO;
                end else begin
                    w_multi_res = r_pacc;
                end
            end
            default: w_multi_res = RES_ZERO;
        endcase
    end

    // Entry write source: fresh single-cycle op in IDLE, captured op on the last BUSY edge
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_ptr = r_cap_ptr;
        w_wr_op  = r_cap_op;
        w_wr_a   = r_cap_a;
        w_wr_b   = r_cap_b;
        w_wr_res = w_multi_res;
        if (r_state == S_IDLE) begin
            if (w_accept && w_is_single) begin
                w_wr_en  = 1'b1;
                w_wr_ptr = w_tgt_ptr;
                w_wr_op  = opcode;
                w_wr_a   = operand_a;
                w_wr_b   = operand_b;
                w_wr_res = f_single(opcode, w_a_ext, w_b_ext);
            end else begin
                w_wr_en = 1'b0;
            end
        end else begin
            w_wr_en = w_last;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_multi) begin
                    w_state_nxt = S_BUSY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_BUSY;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture on accept, then one divide step and one square-and-multiply step per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap_op  <= 4'd0;
            r_cap_a   <= {OP_WIDTH{1'b0}};
            r_cap_b   <= {OP_WIDTH{1'b0}};
            r_cap_ptr <= {AW{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_quot    <= {OP_WIDTH{1'b0}};
            r_rem     <= {OP_WIDTH{1'b0}};
            r_div     <= {OP_WIDTH{1'b0}};
            r_pacc    <= RES_ZERO;
            r_pbase   <= RES_ZERO;
            r_pexp    <= {OP_WIDTH{1'b0}};
        end else if (w_accept && w_is_multi) begin
            r_cap_op  <= opcode;
            r_cap_a   <= operand_a;
            r_cap_b   <= operand_b;
            r_cap_ptr <= w_tgt_ptr;
            r_cnt     <= {CNT_W{1'b0}};
            r_quot    <= w_a_mag;
            r_rem     <= {OP_WIDTH{1'b0}};
            r_div     <= w_b_mag;
            r_pacc    <= RES_ONE;
            r_pbase   <= w_a_ext;
            r_pexp    <= operand_b;
        end else if ((r_state == S_BUSY) && !w_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_rem_sh >= {1'b0, r_div}) begin
                r_rem  <= w_rem_sub[OP_WIDTH-1:0];
                r_quot <= {r_quot[OP_WIDTH-2:0], 1'b1};
            end else begin
                r_rem  <= w_rem_sh[OP_WIDTH-1:0];
                r_quot <= {r_quot[OP_WIDTH-2:0], 1'b0};
            end
            if (r_pexp[0]) begin
                r_pacc <= r_pacc * r_pbase;
            end else begin
                r_pacc <= r_pacc;
            end
            r_pbase <= r_pbase * r_pbase;
            r_pexp  <= r_pexp >> 1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Register file
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_op[i]  <= 4'd0;
                r_mem_a[i]   <= {OP_WIDTH{1'b0}};
                r_mem_b[i]   <= {OP_WIDTH{1'b0}};
                r_mem_res[i] <= RES_ZERO;
            end
            r_mem_valid <= {DEPTH{1'b0}};
        end else if (w_wr_en) begin
            r_mem_op[w_wr_ptr]    <= w_wr_op;
            r_mem_a[w_wr_ptr]     <= w_wr_a;
            r_mem_b[w_wr_ptr]     <= w_wr_b;
            r_mem_res[w_wr_ptr]   <= w_wr_res;
            r_mem_valid[w_wr_ptr] <= 1'b1;
        end else begin
            r_mem_valid <= r_mem_valid;
        end
    end

    // Write counter and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_count    <= {AW{1'b0}};
            r_wr_done     <= 1'b0;
            r_wr_done_ptr <= {AW{1'b0}};
            r_illegal     <= 1'b0;
        end else begin
            r_wr_done <= w_wr_en;
            r_illegal <= w_accept && w_is_illegal;
            if (w_wr_en) begin
                r_wr_count    <= r_wr_count + AW'(1);
                r_wr_done_ptr <= w_wr_ptr;
            end else begin
                r_wr_count    <= r_wr_count;
                r_wr_done_ptr <= r_wr_done_ptr;
            end
        end
    end

    assign rd_opcode    = r_mem_op[read_pointer];
    assign rd_operand_a = r_mem_a[read_pointer];
    assign rd_operand_b = r_mem_b[read_pointer];
    assign rd_result    = r_mem_res[read_pointer];
    assign rd_valid     = r_mem_valid[read_pointer];
    assign wr_done      = r_wr_done;
    assign wr_done_ptr  = r_wr_done_ptr;
    assign wr_count     = r_wr_count;
    assign illegal_op   = r_illegal;

endmodule
